// File: rtl/swd_target_phy_if.sv
// swd_target_phy_if: SWD wire pins plus the request/response/write-data side toward the DP/AP register model
interface swd_target_phy_if;
    logic        swdclk;
    logic        swdin;
    logic        swdout;
    logic        swdoe;
    logic        req_valid;
    logic        req_apndp;
    logic        req_rnw;
    logic [1:0]  req_addr;
    logic        rsp_valid;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_perr;
    logic        line_reset;
    logic        proto_err;
    modport slave (
        input  swdclk, swdin, rsp_valid, rsp_ack, rsp_rdata,
        output swdout, swdoe, req_valid, req_apndp, req_rnw, req_addr,
               wr_valid, wr_data, wr_perr, line_reset, proto_err
    );
    modport master (
        output swdclk, swdin, rsp_valid, rsp_ack, rsp_rdata,
        input  swdout, swdoe, req_valid, req_apndp, req_rnw, req_addr,
               wr_valid, wr_data, wr_perr, line_reset, proto_err
    );
endinterface

// File: rtl/swd_target_phy.sv
// swd_target_phy: oversampled SWD target PHY; decodes requests, drives ACK/read data, receives write data, detects line reset
module swd_target_phy #(
    parameter int SYNC_STAGES = 2,
    parameter int LRST_BITS   = 50
) (
    input logic            clk,
    input logic            rst,
    swd_target_phy_if.slave bus
);
    localparam int LW = $clog2(LRST_BITS + 1);
    typedef enum logic [3:0] {LOCKOUT, RESYNC, IDLE, REQ, TRN1, ACK, RDATA, TRN2, WDATA} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] ck_s, di_s;
    logic ck_d, bit_edge, sdin, lrst, req_ok;
    logic [6:0] rq;
    logic [5:0] bcnt, bcnt_n;
    logic [31:0] sh, sh_n, wr_data, wr_data_n;
    logic [2:0] ack, ack_n;
    logic [1:0] addr, addr_n;
    logic [LW-1:0] lcnt, lcnt_n;
    logic dpar, dpar_n, swdout, swdout_n, swdoe, swdoe_n, apndp, apndp_n, rnw, rnw_n;
    logic wr_perr, wr_perr_n, req_valid, req_valid_n, wr_valid, wr_valid_n;
    logic line_reset, line_reset_n, proto_err, proto_err_n;
    assign bit_edge = ck_s[SYNC_STAGES-1] & ~ck_d;
    assign sdin     = di_s[SYNC_STAGES-1];
    // Request bits as they stand when the park bit arrives: {park, stop, parity, A3, A2, RnW, APnDP}
    assign rq       = {sdin, sh[31:26]};
    assign req_ok   = rq[6] & ~rq[5] & (rq[4] == ^rq[3:0]);
    assign lrst     = bit_edge & sdin & ~swdoe & (lcnt == LW'(LRST_BITS - 1));
    always_comb begin
        state_n      = state;
        bcnt_n       = bcnt;
        sh_n         = sh;
        ack_n        = ack;
        dpar_n       = dpar;
        swdout_n     = swdout;
        swdoe_n      = swdoe;
        apndp_n      = apndp;
        rnw_n        = rnw;
        addr_n       = addr;
        wr_data_n    = wr_data;
        wr_perr_n    = wr_perr;
        lcnt_n       = lcnt;
        req_valid_n  = 1'b0;
        wr_valid_n   = 1'b0;
        line_reset_n = 1'b0;
        proto_err_n  = 1'b0;
        if (bit_edge) begin
            bcnt_n = bcnt + 6'd1;
            lcnt_n = !sdin ? '0 : (!swdoe && lcnt != LW'(LRST_BITS)) ? lcnt + LW'(1) : lcnt;
            case (state)
                RESYNC: state_n = sdin ? RESYNC : IDLE;
                IDLE:   state_n = sdin ? REQ : IDLE;
                REQ: begin
                    sh_n = {sdin, sh[31:1]};
                    if (bcnt == 6'd6) begin
                        state_n     = req_ok ? TRN1 : LOCKOUT;
                        req_valid_n = req_ok;
                        proto_err_n = !req_ok;
                        apndp_n     = req_ok ? rq[0] : apndp;
                        rnw_n       = req_ok ? rq[1] : rnw;
                        addr_n      = req_ok ? rq[3:2] : addr;
                    end
                end
                TRN1: begin
                    ack_n    = bus.rsp_valid ? bus.rsp_ack : 3'b010;
                    sh_n     = bus.rsp_rdata;
                    dpar_n   = ^bus.rsp_rdata;
                    swdoe_n  = 1'b1;
                    swdout_n = ack_n[0];
                    state_n  = ACK;
                end
                ACK: begin
                    swdout_n = bcnt[0] ? ack[2] : ack[1];
                    if (bcnt[0]) state_n = (ack == 3'b001 && rnw) ? RDATA : TRN2;
                end
                RDATA: begin
                    sh_n     = bcnt[5] ? sh : sh >> 1;
                    swdout_n = !bcnt[5] ? sh[0] : (bcnt == 6'd32) ? dpar : 1'b0;
                    swdoe_n  = bcnt != 6'd33;
                    state_n  = (bcnt == 6'd33) ? IDLE : RDATA;
                end
                TRN2: begin
                    swdoe_n = 1'b0;
                    state_n = (ack == 3'b001 && !rnw) ? WDATA : IDLE;
                end
                WDATA: begin
                    if (!bcnt[5]) sh_n = {sdin, sh[31:1]};
                    else begin
                        wr_data_n  = sh;
                        wr_perr_n  = sdin ^ (^sh);
                        wr_valid_n = 1'b1;
                        state_n    = IDLE;
                    end
                end
                default: ;
            endcase
            if (state_n != state) bcnt_n = '0;
            // Line reset overrides whatever the protocol decided on this edge
            if (lrst) begin
                state_n      = RESYNC;
                bcnt_n       = '0;
                swdoe_n      = 1'b0;
                swdout_n     = 1'b0;
                line_reset_n = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ck_s       <= '0;
            di_s       <= '0;
            ck_d       <= 1'b0;
            state      <= LOCKOUT;
            bcnt       <= '0;
            sh         <= '0;
            ack        <= '0;
            dpar       <= 1'b0;
            swdout     <= 1'b0;
            swdoe      <= 1'b0;
            apndp      <= 1'b0;
            rnw        <= 1'b0;
            addr       <= '0;
            wr_data    <= '0;
            wr_perr    <= 1'b0;
            lcnt       <= '0;
            req_valid  <= 1'b0;
            wr_valid   <= 1'b0;
            line_reset <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            ck_s       <= {ck_s[SYNC_STAGES-2:0], bus.swdclk};
            di_s       <= {di_s[SYNC_STAGES-2:0], bus.swdin};
            ck_d       <= ck_s[SYNC_STAGES-1];
            state      <= state_n;
            bcnt       <= bcnt_n;
            sh         <= sh_n;
            ack        <= ack_n;
            dpar       <= dpar_n;
            swdout     <= swdout_n;
            swdoe      <= swdoe_n;
            apndp      <= apndp_n;
            rnw        <= rnw_n;
            addr       <= addr_n;
            wr_data    <= wr_data_n;
            wr_perr    <= wr_perr_n;
            lcnt       <= lcnt_n;
            req_valid  <= req_valid_n;
            wr_valid   <= wr_valid_n;
            line_reset <= line_reset_n;
            proto_err  <= proto_err_n;
        end
    end
    assign bus.swdout     = swdout;
    assign bus.swdoe      = swdoe;
    assign bus.req_valid  = req_valid;
    assign bus.req_apndp  = apndp;
    assign bus.req_rnw    = rnw;
    assign bus.req_addr   = addr;
    assign bus.wr_valid   = wr_valid;
    assign bus.wr_data    = wr_data;
    assign bus.wr_perr    = wr_perr;
    assign bus.line_reset = line_reset;
    assign bus.proto_err  = proto_err;
endmodule

// File: tb/tb_swd_target_phy.sv
// tb_swd_target_phy: host-side SWD bit driver with a protocol-level model of expected target responses
module tb_swd_target_phy;
    logic clk = 1'b0, rst = 1'b1, swdclk = 1'b0, swdin = 1'b0;
    logic rsp_valid = 1'b0;
    logic [2:0] rsp_ack = 3'b001;
    logic [31:0] rsp_rdata = '0;
    int n_checks = 0, n_errors = 0;
    int req_cnt = 0, perr_cnt = 0, wr_cnt = 0, lr_cnt = 0;
    int ab_req_cnt = 0, ab_wr_cnt = 0, ab_lr_cnt = 0;
    logic [31:0] wr_cap = '0;
    logic perr_cap = 1'b0;
    bit locked = 1'b1;
    swd_target_phy_if bus();
    swd_target_phy_if ab();
    assign bus.swdclk = swdclk;
    assign bus.swdin = swdin;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_ack = rsp_ack;
    assign bus.rsp_rdata = rsp_rdata;
    assign ab.swdclk = swdclk;
    assign ab.swdin = swdin;
    assign ab.rsp_valid = rsp_valid;
    assign ab.rsp_ack = rsp_ack;
    assign ab.rsp_rdata = rsp_rdata;
    swd_target_phy dut (.clk(clk), .rst(rst), .bus(bus));
    // Short line-reset threshold so a reset can land inside the write data phase
    swd_target_phy #(.LRST_BITS(24)) dut_ab (.clk(clk), .rst(rst), .bus(ab));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.req_valid) req_cnt++;
        if (bus.proto_err) perr_cnt++;
        if (bus.line_reset) lr_cnt++;
        if (bus.wr_valid) begin wr_cnt++; wr_cap = bus.wr_data; perr_cap = bus.wr_perr; end
        if (ab.req_valid) ab_req_cnt++;
        if (ab.wr_valid) ab_wr_cnt++;
        if (ab.line_reset) ab_lr_cnt++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic host_bit(input logic din, output logic oe, output logic dout);
        swdin = din;
        repeat (4) @(posedge clk); #1;
        swdclk = 1'b1;
        repeat (8) @(posedge clk); #1;
        oe = bus.swdoe;
        dout = bus.swdout;
        swdclk = 1'b0;
        repeat (4) @(posedge clk); #1;
    endtask
    function automatic logic [7:0] packet(input logic apndp, rnw, input logic [1:0] a, input logic bad_par, bad_stop);
        return {1'b1, bad_stop, (^{apndp, rnw, a}) ^ bad_par, a[1], a[0], rnw, apndp, 1'b1};
    endfunction
    task automatic send_ones(input int n);
        logic oe, d;
        int l0 = lr_cnt;
        for (int i = 0; i < n; i++) host_bit(1'b1, oe, d);
        host_bit(1'b0, oe, d);
        host_bit(1'b0, oe, d);
        check("line_reset", 32'(lr_cnt - l0), 32'(n >= 50));
        if (n >= 50) locked = 1'b0;
    endtask
    task automatic txn(input logic apndp, rnw, input logic [1:0] a, input logic bad_par, bad_stop, rv,
                       input logic [2:0] rack, input logic [31:0] rdata, wdata, input logic wperr);
        logic oe, d, any_oe, all_oe, acc;
        logic [7:0] pk;
        logic [2:0] oack, ack_e;
        logic [31:0] od;
        int rq0 = req_cnt, pe0 = perr_cnt, wr0 = wr_cnt;
        rsp_valid = rv; rsp_ack = rack; rsp_rdata = rdata;
        pk = packet(apndp, rnw, a, bad_par, bad_stop);
        any_oe = 1'b0;
        for (int i = 0; i < 8; i++) begin host_bit(pk[i], oe, d); any_oe |= oe; end
        acc = !locked && !bad_par && !bad_stop;
        check("req_oe", 32'(any_oe), 32'(0));
        check("req_valid", 32'(req_cnt - rq0), 32'(acc));
        check("proto_err", 32'(perr_cnt - pe0), 32'(!locked && !acc));
        if (!locked && !acc) locked = 1'b1;
        if (acc) begin
            check("req_fields", {28'd0, bus.req_apndp, bus.req_rnw, bus.req_addr}, {28'd0, apndp, rnw, a});
            ack_e = rv ? rack : 3'b010;
            all_oe = 1'b1;
            for (int i = 0; i < 3; i++) begin host_bit(1'b0, oe, d); oack[i] = d; all_oe &= oe; end
            check("ack", 32'(oack), 32'(ack_e));
            if (ack_e == 3'b001 && rnw) begin
                for (int i = 0; i < 32; i++) begin host_bit(1'b0, oe, d); od[i] = d; all_oe &= oe; end
                check("rdata", od, rdata);
                host_bit(1'b0, oe, d);
                all_oe &= oe;
                check("rparity", 32'(d), 32'(^rdata));
                check("drive_oe", 32'(all_oe), 32'(1));
                host_bit(1'b0, oe, d);
                check("rd_release", 32'(oe), 32'(0));
            end else begin
                check("drive_oe", 32'(all_oe), 32'(1));
                host_bit(1'b0, oe, d);
                check("trn2_release", 32'(oe), 32'(0));
                if (ack_e == 3'b001) begin
                    for (int i = 0; i < 32; i++) host_bit(wdata[i], oe, d);
                    host_bit((^wdata) ^ wperr, oe, d);
                    check("wr_valid", 32'(wr_cnt - wr0), 32'(1));
                    check("wr_data", wr_cap, wdata);
                    check("wr_perr", 32'(perr_cap), 32'(wperr));
                end else check("wr_none", 32'(wr_cnt - wr0), 32'(0));
            end
        end
        host_bit(1'b0, oe, d);
        host_bit(1'b0, oe, d);
    endtask
    initial begin
        logic oe, d;
        logic [7:0] pk;
        logic [2:0] acks [3] = '{3'b001, 3'b010, 3'b100};
        int c0, c1, c2;
        repeat (5) @(posedge clk); #1;
        rst = 1'b0;
        check("rst_oe", 32'(bus.swdoe), 32'(0));
        check("rst_out", 32'(bus.swdout), 32'(0));
        check("rst_req", {27'd0, bus.req_valid, bus.req_apndp, bus.req_rnw, bus.req_addr}, 32'd0);
        check("rst_wr", {bus.wr_data[31:3], bus.wr_valid, bus.wr_perr, bus.line_reset | bus.proto_err}, 32'd0);
        txn(0, 1, 2'b00, 0, 0, 1, 3'b001, 32'h2BA01477, 0, 0);
        send_ones(49);
        txn(0, 1, 2'b00, 0, 0, 1, 3'b001, 32'h2BA01477, 0, 0);
        send_ones(50);
        txn(0, 1, 2'b00, 0, 0, 1, 3'b001, 32'h2BA01477, 0, 0);
        txn(1, 0, 2'b01, 0, 0, 1, 3'b001, 0, 32'hDEADBEEF, 0);
        txn(1, 0, 2'b01, 0, 0, 1, 3'b001, 0, 32'hDEADBEEF, 1);
        txn(0, 1, 2'b11, 0, 0, 0, 3'b001, 32'h12345678, 0, 0);
        txn(1, 1, 2'b10, 0, 0, 1, 3'b001, 32'hA5A5F00F, 0, 0);
        txn(0, 1, 2'b01, 1, 0, 1, 3'b001, 32'h1, 0, 0);
        txn(0, 1, 2'b01, 0, 0, 1, 3'b001, 32'h1, 0, 0);
        send_ones(50);
        txn(1, 0, 2'b00, 0, 1, 1, 3'b001, 0, 32'h55, 0);
        send_ones(56);
        for (int t = 0; t < 20; t++) begin
            txn(1'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) != 0, acks[$urandom_range(0, 2)], $urandom, $urandom, 1'($urandom));
            if (locked) send_ones(50 + $urandom_range(0, 3));
        end
        // Line reset landing inside the write data phase of the short-threshold instance
        rst = 1'b1; repeat (3) @(posedge clk); #1; rst = 1'b0; locked = 1'b1;
        c0 = ab_lr_cnt;
        send_ones(55);
        check("ab_lr_once", 32'(ab_lr_cnt - c0), 32'(1));
        rsp_valid = 1'b1; rsp_ack = 3'b001;
        pk = packet(1, 0, 2'b01, 0, 0);
        c0 = ab_lr_cnt; c1 = ab_wr_cnt; c2 = wr_cnt;
        for (int i = 0; i < 8; i++) host_bit(pk[i], oe, d);
        for (int i = 0; i < 4; i++) host_bit(1'b0, oe, d);
        for (int i = 0; i < 30; i++) host_bit(1'b1, oe, d);
        check("ab_lr_wdata", 32'(ab_lr_cnt - c0), 32'(1));
        check("ab_no_wr", 32'(ab_wr_cnt - c1), 32'(0));
        check("ab_oe", 32'(ab.swdoe), 32'(0));
        for (int i = 0; i < 2; i++) host_bit(1'b1, oe, d);
        host_bit(1'b0, oe, d);
        check("main_wr", 32'(wr_cnt - c2), 32'(1));
        check("main_wr_data", wr_cap, 32'hFFFFFFFF);
        host_bit(1'b0, oe, d);
        host_bit(1'b0, oe, d);
        c0 = ab_req_cnt;
        txn(0, 1, 2'b10, 0, 0, 1, 3'b001, 32'hCAFEF00D, 0, 0);
        check("ab_resync_req", 32'(ab_req_cnt - c0), 32'(1));
        // RESET in the middle of read data
        rsp_valid = 1'b1; rsp_ack = 3'b001; rsp_rdata = 32'hFFFFFFFF;
        pk = packet(0, 1, 2'b00, 0, 0);
        for (int i = 0; i < 8; i++) host_bit(pk[i], oe, d);
        for (int i = 0; i < 13; i++) host_bit(1'b0, oe, d);
        swdin = 1'b0;
        repeat (4) @(posedge clk); #1;
        swdclk = 1'b1;
        repeat (8) @(posedge clk); #1;
        check("rdata_oe", 32'(bus.swdoe), 32'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_oe", 32'(bus.swdoe), 32'(0));
        swdclk = 1'b0;
        repeat (4) @(posedge clk); #1;
        rst = 1'b0; locked = 1'b1;
        txn(0, 1, 2'b00, 0, 0, 1, 3'b001, 32'h2BA01477, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
